// File: rtl/vector_recorder_pkg.sv
// Shared types and constants for the response-capture buffer.
// Sample bundle layout is {a, b, cin, cout, sum} with sum in bit 0.
package vector_recorder_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        HOLD    = 2'd2
    } rec_state_t;

    localparam int unsigned DEF_WIDTH = 5;
    localparam int unsigned DEF_DEPTH = 8;

    localparam int unsigned FLD_SUM  = 0;
    localparam int unsigned FLD_COUT = 1;
    localparam int unsigned FLD_CIN  = 2;
    localparam int unsigned FLD_B    = 3;
    localparam int unsigned FLD_A    = 4;

    function automatic logic [DEF_WIDTH-1:0] pack_vector(
        input logic a,
        input logic b,
        input logic cin,
        input logic cout,
        input logic sum
    );
        logic [DEF_WIDTH-1:0] v;
        v           = '0;
        v[FLD_A]    = a;
        v[FLD_B]    = b;
        v[FLD_CIN]  = cin;
        v[FLD_COUT] = cout;
        v[FLD_SUM]  = sum;
        return v;
    endfunction

endpackage

// File: rtl/vector_recorder_mem.sv
// Simple dual-port RAM: synchronous write, registered read.
// Only the read register is reset; the array itself is never cleared.
module rec_mem #(
    parameter int unsigned WIDTH = 5,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // rdata holds its last value when re is low
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/vector_recorder.sv
// Response-capture buffer: records qualified samples during a run, then
// drains them in order through a read handshake with registered data.
module vector_recorder
    import vector_recorder_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              sample_valid,
    input  logic [WIDTH-1:0]  sample_data,
    input  logic              rd_en,
    output logic [WIDTH-1:0]  rd_data,
    output logic              rd_valid,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              full,
    output logic              done
);

    localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W + 1)'(DEPTH - 1);

    rec_state_t        state_q;
    logic [ADDR_W:0]   wr_ptr_q;
    logic [ADDR_W:0]   rd_ptr_q;
    logic              mem_we;
    logic              mem_re;
    logic              last_read;

    always_comb begin
        mem_we    = (state_q == CAPTURE) && sample_valid;
        mem_re    = (state_q == HOLD) && rd_en && (rd_ptr_q < count);
        last_read = (rd_ptr_q + 1'b1) == count;
    end

    rec_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (mem_we),
        .waddr (wr_ptr_q[ADDR_W-1:0]),
        .wdata (sample_data),
        .re    (mem_re),
        .raddr (rd_ptr_q[ADDR_W-1:0]),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count    <= '0;
            rd_valid <= 1'b0;
            busy     <= 1'b0;
            full     <= 1'b0;
            done     <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            done     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q  <= CAPTURE;
                        busy     <= 1'b1;
                        full     <= 1'b0;
                        wr_ptr_q <= '0;
                        rd_ptr_q <= '0;
                        count    <= '0;
                    end
                end
                CAPTURE: begin
                    if (sample_valid) begin
                        wr_ptr_q <= wr_ptr_q + 1'b1;
                        count    <= count + 1'b1;
                    end
                    if (sample_valid && count == LAST_CNT) begin
                        state_q <= HOLD;
                        busy    <= 1'b0;
                        full    <= 1'b1;
                    end else if (stop) begin
                        busy <= 1'b0;
                        // An empty run has nothing to drain, so skip HOLD
                        state_q <= (sample_valid || count != '0) ? HOLD : IDLE;
                    end
                end
                HOLD: begin
                    if (mem_re) begin
                        rd_valid <= 1'b1;
                        rd_ptr_q <= rd_ptr_q + 1'b1;
                        if (last_read) begin
                            done    <= 1'b1;
                            full    <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vector_recorder.sv
// Self-checking bench for vector_recorder: directed plan steps plus random
// runs, checked every cycle against a queue-based model of the recorder.
module tb_vector_recorder;
    import vector_recorder_pkg::*;

    localparam int unsigned W = 5;
    localparam int unsigned D = 8;

    typedef enum {MIdle, MCap, MHold} mmode_t;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic         sample_valid = 1'b0;
    logic [W-1:0] sample_data = '0;
    logic         rd_en = 1'b0;
    logic [W-1:0] rd_data;
    logic         rd_valid;
    logic [3:0]   count;
    logic         busy;
    logic         full;
    logic         done;

    int n_checks = 0;
    int n_fail = 0;

    // Model: what has been captured, how far it has been read, last read word
    mmode_t       m_mode = MIdle;
    logic [W-1:0] m_q[$];
    int           m_rd_idx = 0;
    logic [W-1:0] m_rd_data = '0;
    int           m_done_seen = 0;

    logic [W-1:0] plan_vec [8];

    vector_recorder #(
        .WIDTH (W),
        .DEPTH (D)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .stop         (stop),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .count        (count),
        .busy         (busy),
        .full         (full),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input bit exp_rv, input bit exp_done);
        check({tag, ".rd_valid"}, 32'(rd_valid), 32'(exp_rv));
        check({tag, ".done"}, 32'(done), 32'(exp_done));
        check({tag, ".rd_data"}, 32'(rd_data), 32'(m_rd_data));
        check({tag, ".count"}, 32'(count), m_q.size());
        check({tag, ".busy"}, 32'(busy), 32'(m_mode == MCap));
        check({tag, ".full"}, 32'(full), 32'(m_mode == MHold && m_q.size() == D));
    endtask

    // Apply the current inputs for one clock, advance the model, check outputs.
    task automatic cycle(input string tag);
        bit exp_rv;
        bit exp_done;
        exp_rv = 1'b0;
        exp_done = 1'b0;
        case (m_mode)
            MIdle: begin
                if (start) begin
                    m_mode = MCap;
                    m_q.delete();
                    m_rd_idx = 0;
                end
            end
            MCap: begin
                if (sample_valid) m_q.push_back(sample_data);
                if (m_q.size() == D) m_mode = MHold;
                else if (stop) m_mode = (m_q.size() == 0) ? MIdle : MHold;
            end
            MHold: begin
                if (rd_en && m_rd_idx < m_q.size()) begin
                    exp_rv = 1'b1;
                    m_rd_data = m_q[m_rd_idx];
                    m_rd_idx++;
                    if (m_rd_idx == m_q.size()) begin
                        exp_done = 1'b1;
                        m_done_seen++;
                        m_mode = MIdle;
                    end
                end
            end
            default: m_mode = MIdle;
        endcase
        @(posedge clk);
        #1;
        check_all(tag, exp_rv, exp_done);
    endtask

    task automatic idle_inputs();
        start = 1'b0;
        stop = 1'b0;
        sample_valid = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic arm();
        idle_inputs();
        start = 1'b1;
        cycle("arm");
        start = 1'b0;
    endtask

    task automatic drain(input string tag, input int n);
        idle_inputs();
        rd_en = 1'b1;
        for (int i = 0; i < n; i++) cycle(tag);
        cycle({tag, "_after"});
        rd_en = 1'b0;
    endtask

    initial begin
        int n_done;
        plan_vec = '{5'b00000, 5'b00101, 5'b01001, 5'b01110,
                     5'b10001, 5'b10110, 5'b11010, 5'b11111};

        #2;
        check_all("reset", 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        // Reset mid-capture after three writes abandons the run
        arm();
        sample_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sample_data = W'($urandom);
            cycle("cap3");
        end
        idle_inputs();
        @(negedge clk);
        reset = 1'b0;
        #1;
        m_mode = MIdle;
        m_q.delete();
        m_rd_idx = 0;
        m_rd_data = '0;
        check_all("mid_reset", 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        rd_en = 1'b1;
        cycle("post_reset_rd");
        n_done = m_done_seen;
        arm();
        sample_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            sample_data = W'($urandom);
            cycle("cap2");
        end
        sample_valid = 1'b0;
        stop = 1'b1;
        cycle("stop2");
        drain("drain2", 2);
        check("done_once", 32'(m_done_seen - n_done), 32'd1);

        // Eight fixed samples fill the buffer; extra samples and start ignored
        arm();
        sample_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sample_data = plan_vec[i];
            cycle("fill8");
        end
        check("full_after_8", 32'(full), 32'd1);
        sample_data = 5'b10101;
        cycle("ninth_sample");
        cycle("hold_sample");
        sample_valid = 1'b0;
        start = 1'b1;
        cycle("hold_start");
        start = 1'b0;
        drain("drain8", 8);
        check("count_kept", 32'(count), 32'd8);
        for (int i = 0; i < 8; i++) begin
            check("plan_model", 32'(m_q[i]), 32'(plan_vec[i]));
        end

        // Stop together with a third sample; rd_en during capture ignored
        arm();
        rd_en = 1'b1;
        sample_valid = 1'b1;
        sample_data = 5'b10110;
        cycle("cap_a");
        sample_data = 5'b01001;
        cycle("cap_b");
        sample_data = 5'b11111;
        stop = 1'b1;
        cycle("cap_stop");
        idle_inputs();
        check("count3", 32'(count), 32'd3);
        cycle("hold_gap");
        drain("drain3", 3);

        // Immediate stop: empty run returns to IDLE with no done
        n_done = m_done_seen;
        arm();
        stop = 1'b1;
        cycle("empty_stop");
        stop = 1'b0;
        rd_en = 1'b1;
        cycle("empty_rd0");
        cycle("empty_rd1");
        rd_en = 1'b0;
        check("empty_no_done", 32'(m_done_seen - n_done), 32'd0);

        // Random runs with random handshakes and ignored-input noise
        for (int run = 0; run < 12; run++) begin
            arm();
            for (int c = 0; c < 24 && m_mode == MCap; c++) begin
                sample_valid = 1'($urandom);
                sample_data = W'($urandom);
                stop = ($urandom_range(0, 6) == 0);
                rd_en = 1'($urandom);
                start = 1'($urandom);
                cycle("rand_cap");
            end
            if (m_mode == MCap) begin
                idle_inputs();
                stop = 1'b1;
                cycle("rand_force_stop");
            end
            for (int c = 0; c < 60 && m_mode == MHold; c++) begin
                idle_inputs();
                rd_en = ($urandom_range(0, 3) != 0);
                sample_valid = 1'($urandom);
                sample_data = W'($urandom);
                start = ($urandom_range(0, 4) == 0);
                stop = 1'($urandom);
                cycle("rand_drain");
            end
            idle_inputs();
            cycle("rand_idle");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vector_recorder.md
Name: vector_recorder

Overview:
- Synthesizable response-capture buffer, the writer counterpart to the file-driven vector reader used by the team's benches.
- Samples a WIDTH-bit bundle ({a,b,cin,cout,sum} for the adder flow) on each qualified clock and stores it in on-chip memory.
- Stored entries are drained in order through a read handshake, so the run can be dumped and compared offline against the expected-vector file.

Parameters:
- WIDTH, 5, bits per captured sample; matches the vector line format {a,b,cin,cout,sum}.
- DEPTH, 8, number of entries; must be >= 2 and need not be a power of two.
- ADDR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that arms a capture run.
- stop  in  1  ends capture early.
- sample_valid  in  1  capture sample_data this cycle.
- sample_data  in  WIDTH  bundle to record.
- rd_en  in  1  request the next stored entry.
- rd_data  out  WIDTH  registered read data.
- rd_valid  out  1  rd_data is valid this cycle.
- count  out  ADDR_W+1  entries currently held.
- busy  out  1  high in CAPTURE.
- full  out  1  count == DEPTH.
- done  out  1  one-cycle pulse when the last entry has been read.

Behaviour:
- Reset (reset == 0, asynchronous):
  - state = IDLE; wr_ptr = rd_ptr = count = 0.
  - rd_data = 0; rd_valid = busy = full = done = 0.
  - Memory contents are not cleared and are don't-care.
  - Reset asserted mid-run abandons the run; no done pulse.
- IDLE:
  - start -> CAPTURE; wr_ptr, rd_ptr and count cleared on that edge.
  - sample_valid, rd_en and stop are ignored.
- CAPTURE (busy = 1):
  - Each cycle with sample_valid: mem[wr_ptr] <= sample_data; wr_ptr++ and count++ on the same edge.
  - When count reaches DEPTH -> HOLD; full asserts in the cycle after the DEPTH-th write.
  - stop -> HOLD. stop together with sample_valid writes that sample first, then goes to HOLD.
  - stop with count == 0 -> IDLE directly, with no done pulse.
  - start is ignored; rd_en is ignored.
- HOLD:
  - rd_en with rd_ptr < count: read mem[rd_ptr]. rd_data and rd_valid are registered, so there is one cycle of latency after the rd_en edge. rd_ptr++.
  - rd_en may be held high; this gives back-to-back reads of one entry per cycle.
  - When the read of entry count-1 is issued: done pulses in the same cycle as that rd_valid, state -> IDLE, full clears.
  - rd_en with nothing left to read produces no rd_valid.
  - sample_valid and start are ignored.
- rd_valid is 0 in every cycle without a read. rd_data holds its last value between reads.
- Pointers never wrap. Writes beyond DEPTH are impossible because CAPTURE exits at full.
- count keeps its value through HOLD. It clears only on start or reset; it is not decremented by reads.

Decomposition:
- vector_recorder_pkg:
  - state enum rec_state_t {IDLE, CAPTURE, HOLD}.
  - default WIDTH/DEPTH localparams.
  - field-position constants for {a,b,cin,cout,sum}.
- Sub-module rec_mem: simple dual-port RAM.
  - One synchronous write port (we, waddr, wdata).
  - One registered read port (re, raddr, rdata).
  - No reset on the array.
- vector_recorder holds the FSM, pointers, count, and the rd_valid/done registers.

Test Plan:
- Reset mid-CAPTURE after 3 writes -> all outputs 0, state IDLE; next start + 2 samples + stop, drained -> 2 entries read, done pulses once.
- start, 8 consecutive samples 00000,00101,01001,01110,10001,10110,11010,11111 -> full = 1 after 8th edge, busy = 0; 8 rd_en cycles -> rd_data sequence identical, rd_valid each cycle, done with 8th rd_valid, count = 8.
- start, samples 10110 and 01001, stop asserted with a third sample 11111 -> count = 3, full = 0; drain returns 10110, 01001, 11111.
- start then immediate stop, no samples -> returns to IDLE, count = 0, no done, rd_en yields no rd_valid.
- Attempted 9th sample_valid after full, and sample_valid during HOLD -> ignored, count stays 8, drained data unchanged.
- rd_en asserted during CAPTURE and start pulsed during HOLD -> no rd_valid during CAPTURE, HOLD contents and rd_ptr unaffected by start.
